// File: rtl/i2s_mic_rx_if.sv
// i2s_mic_rx_if: microphone pins and PCM output bundle for i2s_mic_rx.
// err_cnt exists only when I2S_MIC_RX_ERR_CNT_EN is defined.
interface i2s_mic_rx_if #(
   parameter int DATA_W = 24
);
   logic              mic_sck;
   logic              mic_ws;
   logic              mic_sd;
   logic [DATA_W-1:0] pcm_data;
   logic              pcm_ch;
   logic              pcm_valid;
   logic              frame_err;
`ifdef I2S_MIC_RX_ERR_CNT_EN
   logic [7:0]        err_cnt;
   modport master (input mic_sck, mic_ws, mic_sd,
                   output pcm_data, pcm_ch, pcm_valid, frame_err, err_cnt);
   modport slave  (output mic_sck, mic_ws, mic_sd,
                   input pcm_data, pcm_ch, pcm_valid, frame_err, err_cnt);
`else
   modport master (input mic_sck, mic_ws, mic_sd,
                   output pcm_data, pcm_ch, pcm_valid, frame_err);
   modport slave  (output mic_sck, mic_ws, mic_sd,
                   input pcm_data, pcm_ch, pcm_valid, frame_err);
`endif
endinterface

// File: rtl/i2s_mic_rx.sv
// i2s_mic_rx: oversampled I2S microphone receiver producing parallel PCM words.
// Optional saturating error counter enabled by I2S_MIC_RX_ERR_CNT_EN.
module i2s_mic_rx #(
   parameter int DATA_W      = 24,
   parameter int SLOT_W      = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk_in,
   input  logic          rst_n,
   i2s_mic_rx_if.master  bus
);
   typedef enum logic [1:0] {WAIT_WS, DELAY, SHIFT, HOLD} state_t;
   localparam int BW = $clog2(DATA_W + 1);
   localparam int SW = $clog2(SLOT_W + 1) + 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
   localparam logic [SW-1:0] SLOT_LEN = SW'(SLOT_W);

   if (DATA_W > SLOT_W - 1) begin : g_bad_width
      $error("i2s_mic_rx: DATA_W must not exceed SLOT_W-1");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("i2s_mic_rx: SYNC_STAGES must be at least 2");
   end

   state_t            state, state_n;
   logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
   logic              sck_d, ws_prev, ch, ch_n;
   logic              sync_sck, ws_s, sd_s, sck_rise, ws_edge;
   logic [DATA_W-1:0] shreg, shreg_n, shifted;
   logic [BW-1:0]     bit_cnt, bit_n;
   logic [SW-1:0]     slot_cnt, slot_n;
   logic              valid_n, err_n;

   assign sync_sck = sck_sync[SYNC_STAGES-1];
   assign ws_s     = ws_sync[SYNC_STAGES-1];
   assign sd_s     = sd_sync[SYNC_STAGES-1];
   assign sck_rise = sync_sck & ~sck_d;
   assign ws_edge  = sck_rise & (ws_s ^ ws_prev);
   assign shifted  = {shreg[DATA_W-2:0], sd_s};

   // A WS edge always wins over a data bit arriving on the same sck edge.
   always_comb begin
      state_n = state;
      ch_n    = ch;
      shreg_n = shreg;
      bit_n   = bit_cnt;
      slot_n  = slot_cnt;
      valid_n = 1'b0;
      err_n   = 1'b0;
      if (ws_edge) begin
         err_n   = (state != WAIT_WS) &&
                   (slot_cnt != SLOT_LEN || state == DELAY || state == SHIFT);
         ch_n    = ws_s;
         slot_n  = SW'(1);
         state_n = DELAY;
      end else if (sck_rise) begin
         slot_n = (&slot_cnt) ? slot_cnt : slot_cnt + 1'b1;
         if (state == DELAY || state == SHIFT) begin
            shreg_n = shifted;
            bit_n   = (state == DELAY) ? BW'(1) : bit_cnt + 1'b1;
            valid_n = (state == SHIFT) && (bit_cnt == LAST_BIT);
            state_n = valid_n ? HOLD : SHIFT;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         sck_sync      <= '0;
         ws_sync       <= '0;
         sd_sync       <= '0;
         sck_d         <= 1'b0;
         ws_prev       <= 1'b0;
         state         <= WAIT_WS;
         ch            <= 1'b0;
         shreg         <= '0;
         bit_cnt       <= '0;
         slot_cnt      <= '0;
         bus.pcm_data  <= '0;
         bus.pcm_ch    <= 1'b0;
         bus.pcm_valid <= 1'b0;
         bus.frame_err <= 1'b0;
      end else begin
         sck_sync      <= {sck_sync[SYNC_STAGES-2:0], bus.mic_sck};
         ws_sync       <= {ws_sync[SYNC_STAGES-2:0], bus.mic_ws};
         sd_sync       <= {sd_sync[SYNC_STAGES-2:0], bus.mic_sd};
         sck_d         <= sync_sck;
         ws_prev       <= sck_rise ? ws_s : ws_prev;
         state         <= state_n;
         ch            <= ch_n;
         shreg         <= shreg_n;
         bit_cnt       <= bit_n;
         slot_cnt      <= slot_n;
         bus.pcm_valid <= valid_n;
         bus.frame_err <= err_n;
         if (valid_n) begin
            bus.pcm_data <= shifted;
            bus.pcm_ch   <= ch;
         end
      end
   end

`ifdef I2S_MIC_RX_ERR_CNT_EN
   always_ff @(posedge clk_in) begin
      if (!rst_n)
         bus.err_cnt <= '0;
      else if (bus.frame_err && !(&bus.err_cnt))
         bus.err_cnt <= bus.err_cnt + 1'b1;
   end
`endif
endmodule
